// File: rtl/kv_pkg.sv
// kv_pkg: shared widths, command record and FSM state type for the key-value request sequencer
package kv_pkg;
  localparam int KV_AW = 7;
  localparam int KV_DW = 7;
  typedef struct packed {
    logic             we;
    logic             adr_is_key;
    logic             dat_is_key;
    logic [KV_AW-1:0] adr;
    logic [KV_DW-1:0] dat;
  } kv_cmd_t;
  typedef enum logic [1:0] {IDLE, REQ, RSP} kv_state_t;
endpackage

// File: rtl/kv_cmd_fifo.sv
// kv_cmd_fifo: power-of-two command FIFO; no bypass, pushes while full are dropped
module kv_cmd_fifo
  import kv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = kv_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/kv_req_sequencer.sv
// kv_req_sequencer: queues host commands and runs them one at a time against the
// key-value store's strobe/ACK port, returning one response (data, dup, timeout) per command
module kv_req_sequencer
  import kv_pkg::*;
#(
  parameter int AW      = 7,
  parameter int DW      = 7,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst_1,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic          cmd_adr_is_key,
  input  logic          cmd_dat_is_key,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  output logic          kv_stb_o,
  output logic          kv_we_o,
  output logic          kv_adr_is_key_o,
  output logic          kv_dat_is_key_o,
  output logic [AW-1:0] kv_adr_o,
  output logic [DW-1:0] kv_dat_o,
  input  logic          kv_ack_i,
  input  logic [DW-1:0] kv_dat_i,
  input  logic          kv_dup_i,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_dup,
  output logic          rsp_timeout,
  output logic          busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic          we;
    logic          adr_is_key;
    logic          dat_is_key;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } cmd_t;
  kv_state_t state, nxt;
  cmd_t cmd_in, head;
  logic full, empty, pop, ack, expire;
  logic [CW-1:0] count;
  logic [TW-1:0] tmo;
  assign cmd_in    = '{we: cmd_we, adr_is_key: cmd_adr_is_key, dat_is_key: cmd_dat_is_key,
                       adr: cmd_adr, dat: cmd_dat};
  assign cmd_ready = !full;
  assign pop       = state == IDLE && !empty;
  assign ack       = state == REQ && kv_ack_i;
  // ACK wins over an expiry landing on the same edge
  assign expire    = state == REQ && !kv_ack_i && tmo == TW'(TIMEOUT - 1);
  assign busy      = state != IDLE || count != '0;
  kv_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .clk(sys_clk), .rst_n(sys_rst_1), .push(cmd_valid), .pop(pop), .wdata(cmd_in),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_1) begin
    if (!sys_rst_1) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (pop) nxt = REQ;
    if (ack || expire) nxt = RSP;
    if (state == RSP && rsp_ready) nxt = IDLE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_1) begin
    if (!sys_rst_1) begin
      kv_stb_o        <= 1'b0;
      kv_we_o         <= 1'b0;
      kv_adr_is_key_o <= 1'b0;
      kv_dat_is_key_o <= 1'b0;
      kv_adr_o        <= '0;
      kv_dat_o        <= '0;
      rsp_valid       <= 1'b0;
      rsp_dat         <= '0;
      rsp_dup         <= 1'b0;
      rsp_timeout     <= 1'b0;
      tmo             <= '0;
    end else begin
      if (pop) begin
        kv_stb_o        <= 1'b1;
        kv_we_o         <= head.we;
        kv_adr_is_key_o <= head.adr_is_key;
        kv_dat_is_key_o <= head.dat_is_key;
        kv_adr_o        <= head.adr;
        kv_dat_o        <= head.dat;
        tmo             <= '0;
      end
      if (state == REQ && !ack && tmo != TW'(TIMEOUT)) tmo <= tmo + TW'(1);
      if (ack || expire) begin
        kv_stb_o    <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_timeout <= expire;
        rsp_dat     <= ack ? kv_dat_i : '0;
        rsp_dup     <= ack && kv_dup_i;
      end
      if (state == RSP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_kv_req_sequencer.sv
// tb_kv_req_sequencer: table vectors, hand sequences and random traffic against a
// transaction-level store/response model
module tb_kv_req_sequencer;
  localparam int TO = 8;
  logic sys_clk = 1'b0, sys_rst_1 = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0, cmd_adr_is_key = 1'b0, cmd_dat_is_key = 1'b0;
  logic [6:0] cmd_adr = '0, cmd_dat = '0;
  logic kv_stb_o, kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o;
  logic [6:0] kv_adr_o, kv_dat_o;
  logic kv_ack_i, kv_dup_i;
  logic [6:0] kv_dat_i;
  logic rsp_valid, rsp_ready, rsp_dup, rsp_timeout, busy;
  logic [6:0] rsp_dat;

  kv_req_sequencer #(.AW(7), .DW(7), .DEPTH(4), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_1(sys_rst_1), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr_is_key(cmd_adr_is_key), .cmd_dat_is_key(cmd_dat_is_key),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .kv_stb_o(kv_stb_o), .kv_we_o(kv_we_o),
    .kv_adr_is_key_o(kv_adr_is_key_o), .kv_dat_is_key_o(kv_dat_is_key_o), .kv_adr_o(kv_adr_o),
    .kv_dat_o(kv_dat_o), .kv_ack_i(kv_ack_i), .kv_dat_i(kv_dat_i), .kv_dup_i(kv_dup_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_dup(rsp_dup),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic we, aik, dik;
    logic [6:0] adr, dat;
    int delay;
    logic [6:0] sdat;
    logic sdup;
    int ecyc;
    logic eto;
    logic [6:0] edat;
    logic edup;
  } txn_t;

  int n_cmp = 0, n_bad = 0, n_rsp = 0, n_issued = 0;
  int stb_cnt = 0, gap = 0, rsp_mode = 0;
  logic noise = 1'b0;
  txn_t exp_q[$];
  int gap_log[$];
  txn_t cur, rexp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // store behaviour: ACK on the delay-th strobe cycle; no ACK at all means timeout
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    if (t.delay <= TO) begin
      r.ecyc = t.delay; r.eto = 1'b0; r.edat = t.sdat; r.edup = t.sdup;
    end else begin
      r.ecyc = TO; r.eto = 1'b1; r.edat = '0; r.edup = 1'b0;
    end
    return r;
  endfunction

  function automatic txn_t mk(input logic we, input logic [6:0] adr, input logic [6:0] dat,
                              input int delay, input logic [6:0] sdat, input logic sdup);
    txn_t t;
    t.we = we; t.aik = adr[0]; t.dik = !we; t.adr = adr; t.dat = dat;
    t.delay = delay; t.sdat = sdat; t.sdup = sdup;
    return model(t);
  endfunction

  function automatic txn_t rnd();
    return mk(1'($urandom), 7'($urandom), 7'($urandom), $urandom_range(1, 11), 7'($urandom), 1'($urandom));
  endfunction

  task automatic push(input txn_t t);
    exp_q.push_back(t);
    n_issued++;
    cmd_we = t.we; cmd_adr_is_key = t.aik; cmd_dat_is_key = t.dik; cmd_adr = t.adr; cmd_dat = t.dat;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) step();
    chk("cmd_ready wait", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) step();
    chk("idle reached", busy, 0);
  endtask

  // store + response agent
  initial begin
    kv_ack_i = 1'b0; kv_dat_i = '0; kv_dup_i = 1'b0; rsp_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst_1) begin
        stb_cnt = 0; gap = 0; kv_ack_i = 1'b0;
      end else begin
        if (kv_stb_o) begin
          if (stb_cnt == 0) begin
            gap_log.push_back(gap);
            gap = 0;
            chk("strobe expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            chk("kv_we_o", kv_we_o, cur.we);
            chk("kv_adr_o", kv_adr_o, cur.adr);
            chk("kv_dat_o", kv_dat_o, cur.dat);
            chk("kv_key_flags", {kv_adr_is_key_o, kv_dat_is_key_o}, {cur.aik, cur.dik});
          end else
            chk("request stable", {kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o, kv_adr_o, kv_dat_o},
                {cur.we, cur.aik, cur.dik, cur.adr, cur.dat});
          stb_cnt++;
          kv_ack_i = stb_cnt == cur.delay;
          kv_dat_i = kv_ack_i ? cur.sdat : 7'($urandom);
          kv_dup_i = kv_ack_i ? cur.sdup : 1'($urandom);
        end else begin
          if (stb_cnt != 0) begin
            chk("strobe cycles", stb_cnt, cur.ecyc);
            chk("rsp_valid after strobe", rsp_valid, 1);
            rexp = cur;
            stb_cnt = 0;
          end
          gap++;
          kv_ack_i = noise ? 1'($urandom) : 1'b0;
          kv_dat_i = 7'($urandom);
          kv_dup_i = 1'($urandom);
        end
        rsp_ready = rsp_mode == 0 ? 1'b1 : rsp_mode == 1 ? 1'b0 : 1'($urandom);
        if (rsp_valid && rsp_ready) begin
          chk("rsp_timeout", rsp_timeout, rexp.eto);
          chk("rsp_dat", rsp_dat, rexp.edat);
          chk("rsp_dup", rsp_dup, rexp.edup);
          n_rsp++;
        end
      end
    end
  end

  initial begin
    txn_t tbl[5];
    txn_t t;
    logic [6:0] hold;
    int stale;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 7'h12, 7'h34, 2, 7'h55, 1'b0, 2, 1'b0, 7'h55, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 7'h12, 7'h00, 1, 7'h34, 1'b1, 1, 1'b0, 7'h34, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 7'h7f, 7'h00, 9, 7'h6a, 1'b1, 8, 1'b1, 7'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 7'h01, 7'h00, 8, 7'h2b, 1'b1, 8, 1'b0, 7'h2b, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 7'h00, 7'h7f, 3, 7'h11, 1'b0, 3, 1'b0, 7'h11, 1'b0};

    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset kv_stb_o", kv_stb_o, 0);
    chk("reset kv_req", {kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o, kv_adr_o, kv_dat_o}, 0);
    chk("reset rsp", {rsp_valid, rsp_dat, rsp_dup, rsp_timeout}, 0);
    chk("reset busy", busy, 0);
    sys_rst_1 = 1'b1;
    step();
    chk("cmd_ready after reset", cmd_ready, 1);
    chk("busy after reset", busy, 0);

    push(mk(1'b0, 7'h05, 7'h00, 1, 7'h22, 1'b0));
    chk("stb low after accept edge", kv_stb_o, 0);
    step();
    chk("stb high one edge later", kv_stb_o, 1);
    wait_idle();

    foreach (tbl[i]) push(tbl[i]);
    wait_idle();
    chk("table rsp count", n_rsp, n_issued);

    gap_log.delete();
    for (int i = 0; i < 3; i++) push(mk(1'b0, 7'(7'h40 + i), 7'h00, 1, 7'(i + 1), 1'b0));
    wait_idle();
    chk("b2b gap 1", gap_log.size() > 2 ? gap_log[1] : -1, 2);
    chk("b2b gap 2", gap_log.size() > 2 ? gap_log[2] : -1, 2);

    rsp_mode = 1;
    push(mk(1'b0, 7'h12, 7'h00, 1, 7'h34, 1'b1));
    for (int i = 0; i < 100 && !rsp_valid; i++) step();
    chk("held rsp_valid", rsp_valid, 1);
    hold = rsp_dat;
    chk("held rsp_dat", hold, 7'h34);
    for (int i = 0; i < 4; i++) push(mk(1'b1, 7'(7'h60 + i), 7'(i), 2, 7'(7'h10 + i), 1'b0));
    chk("cmd_ready drops when full", cmd_ready, 0);
    t = mk(1'b1, 7'h6f, 7'h3c, 2, 7'h1f, 1'b1);
    exp_q.push_back(t);
    n_issued++;
    cmd_we = t.we; cmd_adr_is_key = t.aik; cmd_dat_is_key = t.dik; cmd_adr = t.adr; cmd_dat = t.dat;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold rsp_valid", rsp_valid, 1);
      chk("hold rsp_dat", rsp_dat, hold);
      chk("hold no strobe", kv_stb_o, 0);
      chk("hold cmd_ready", cmd_ready, 0);
    end
    rsp_mode = 0;
    for (int i = 0; i < 100 && !cmd_ready; i++) step();
    chk("fifth accepted", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    wait_idle();
    chk("full seq rsp count", n_rsp, n_issued);

    for (int i = 0; i < 4; i++) push(mk(1'b0, 7'(7'h20 + i), 7'h00, 20, 7'h00, 1'b0));
    for (int i = 0; i < 50 && !kv_stb_o; i++) step();
    #2 sys_rst_1 = 1'b0;
    #1;
    chk("async stb drop", kv_stb_o, 0);
    chk("async rsp drop", rsp_valid, 0);
    exp_q.delete();
    n_issued = n_rsp;
    step();
    step();
    sys_rst_1 = 1'b1;
    chk("busy after mid reset", busy, 0);
    chk("cmd_ready after mid reset", cmd_ready, 1);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      stale += int'(kv_stb_o | rsp_valid);
    end
    chk("no stale activity", stale, 0);

    noise = 1'b1;
    rsp_mode = 2;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < $urandom_range(1, 3); k++) push(rnd());
      wait_idle();
    end
    noise = 1'b0;
    rsp_mode = 0;
    chk("random rsp count", n_rsp, n_issued);
    chk("expected queue drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
